// File: rtl/simd_sram_dp.sv
// Dual-port SIMD datapath SRAM: port A read/write with byte enables, port B read-only,
// built-in clear engine and selectable 0/1-cycle read latency.
module simd_sram_dp #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  output logic                    o_ready,
  input  logic [ADDR_WIDTH-1:0]   i_a_addr,
  input  logic                    i_a_write,
  input  logic [DATA_WIDTH/8-1:0] i_a_be,
  input  logic [DATA_WIDTH-1:0]   i_a_data,
  output logic [DATA_WIDTH-1:0]   o_a_data,
  input  logic [ADDR_WIDTH-1:0]   i_b_addr,
  input  logic                    i_b_read,
  output logic [DATA_WIDTH-1:0]   o_b_data,
  output logic                    o_b_valid
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    ready;
  logic                    a_we;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_new;

  assign ready   = (state_q == S_IDLE);
  assign o_ready = ready;
  assign a_we    = ready & i_a_write;
  assign a_old   = mem[i_a_addr];
  assign b_old   = mem[i_b_addr];

  // Byte-merged word that a port A write would leave in the array.
  for (genvar k = 0; k < NB; k++) begin : g_merge
    assign a_new[8*k +: 8] = i_a_be[k] ? i_a_data[8*k +: 8] : a_old[8*k +: 8];
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_IDLE:  if (i_clear) state_d = S_CLEAR;
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array is deliberately not reset; the clear engine owns initialisation.
  always_ff @(posedge i_clk) begin
    if (!ready)    mem[clr_cnt_q] <= CLEAR_VALUE;
    else if (a_we) mem[i_a_addr]  <= a_new;
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign o_a_data  = ready ? a_old : '0;
    assign o_b_data  = ready ? b_old : '0;
    assign o_b_valid = i_b_read & ready;
  end else begin : g_lat1
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  bv_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        a_q  <= '0;
        b_q  <= '0;
        bv_q <= 1'b0;
      end else begin
        bv_q <= i_b_read & ready;
        if (!ready) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_we ? a_new : a_old;
          // Write-first bypass when B reads the word A is writing.
          if (i_b_read) b_q <= (a_we && (i_b_addr == i_a_addr)) ? a_new : b_old;
        end
      end
    end

    assign o_a_data  = a_q;
    assign o_b_data  = b_q;
    assign o_b_valid = bv_q;
  end

endmodule

// File: tb/tb_simd_sram_dp.sv
// Scoreboarded bench for simd_sram_dp: default (latency 1) instance driven by directed and
// random traffic against an array model, plus a small 64-bit latency-0 instance.
module tb_simd_sram_dp;
  localparam int AW = 8, DW = 32, NB = 4, DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst = 1'b0, i_clear = 1'b0, o_ready;
  logic [AW-1:0] i_a_addr = '0, i_b_addr = '0;
  logic          i_a_write = 1'b0, i_b_read = 1'b0, o_b_valid;
  logic [NB-1:0] i_a_be = '0;
  logic [DW-1:0] i_a_data = '0, o_a_data, o_b_data;

  simd_sram_dp u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .o_ready(o_ready),
    .i_a_addr(i_a_addr), .i_a_write(i_a_write), .i_a_be(i_a_be), .i_a_data(i_a_data),
    .o_a_data(o_a_data), .i_b_addr(i_b_addr), .i_b_read(i_b_read),
    .o_b_data(o_b_data), .o_b_valid(o_b_valid)
  );

  logic        d2_rst = 1'b0, d2_clear = 1'b0, d2_ready;
  logic [3:0]  d2_a_addr = '0, d2_b_addr = '0;
  logic        d2_a_write = 1'b0, d2_b_read = 1'b0, d2_b_valid;
  logic [7:0]  d2_a_be = '0;
  logic [63:0] d2_a_data = '0, d2_a_rd, d2_b_rd;

  simd_sram_dp #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .READ_LATENCY(0)) u_dut2 (
    .i_clk(clk), .i_rst(d2_rst), .i_clear(d2_clear), .o_ready(d2_ready),
    .i_a_addr(d2_a_addr), .i_a_write(d2_a_write), .i_a_be(d2_a_be), .i_a_data(d2_a_data),
    .o_a_data(d2_a_rd), .i_b_addr(d2_b_addr), .i_b_read(d2_b_read),
    .o_b_data(d2_b_rd), .o_b_valid(d2_b_valid)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // Reference model: array contents, remaining clear cycles, last word port B returned.
  logic [DW-1:0] mem_m [DEPTH];
  int            busy = 0;
  logic [DW-1:0] bhold_m = '0;

  typedef struct {
    logic          rdy;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cyc_t;
  cyc_t          cq[$];
  logic [DW-1:0] bq[$];

  task automatic cyc(input logic clr, input logic [AW-1:0] aa, input logic wr,
                     input logic [NB-1:0] be, input logic [DW-1:0] d,
                     input logic [AW-1:0] ba, input logic rd);
    cyc_t e;
    logic [DW-1:0] mrg;
    @(negedge clk);
    i_clear = clr; i_a_addr = aa; i_a_write = wr; i_a_be = be; i_a_data = d;
    i_b_addr = ba; i_b_read = rd;
    mrg = wr ? DW'(merge(64'(mem_m[aa]), 64'(d), 8'(be))) : mem_m[aa];
    if (busy == 0) begin
      e.a = mrg;
      if (rd) begin
        bhold_m = (wr && ba == aa) ? mrg : mem_m[ba];
        bq.push_back(bhold_m);
      end
      if (wr) mem_m[aa] = mrg;
      if (clr) busy = DEPTH;
    end else begin
      e.a = '0;
      bhold_m = '0;
      mem_m[DEPTH-busy] = '0;
      busy--;
    end
    e.rdy = (busy == 0);
    e.b = bhold_m;
    cq.push_back(e);
  endtask

  always @(posedge clk) begin : mon
    cyc_t e;
    #1;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("ready", 64'(o_ready), 64'(e.rdy));
      chk("a_data", 64'(o_a_data), 64'(e.a));
      if (o_b_valid) begin
        if (bq.size() == 0) chk("b_valid_spurious", 64'(o_b_valid), 64'd0);
        else                chk("b_data", 64'(o_b_data), 64'(bq.pop_front()));
      end else begin
        chk("b_hold", 64'(o_b_data), 64'(e.b));
      end
    end
  end

  task automatic do_reset(input bit pulse_clear);
    int n;
    @(negedge clk);
    i_rst = 1'b1; i_clear = 1'b0; i_a_write = 1'b0; i_b_read = 1'b0;
    #1;
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_b_valid", 64'(o_b_valid), 64'd0);
    chk("rst_a_data", 64'(o_a_data), 64'd0);
    chk("rst_b_data", 64'(o_b_data), 64'd0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    n = 0;
    do begin
      i_clear = pulse_clear && (n % 50 == 10);
      @(posedge clk); #1;
      n++;
    end while (!o_ready && n < 1000);
    i_clear = 1'b0;
    chk("clear_len_after_reset", 64'(n), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    busy = 0;
    bhold_m = '0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Power-on clear, then sweep every address on both ports.
    do_reset(1'b0);
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, AW'(a), 1'b0, '0, '0, AW'(DEPTH-1-a), 1'b1);

    // Byte-merged writes, then read on both ports.
    cyc(1'b0, 8'h10, 1'b1, 4'b1111, 32'h11223344, 8'h00, 1'b0);
    cyc(1'b0, 8'h10, 1'b1, 4'b0101, 32'hAABBCCDD, 8'h00, 1'b0);
    cyc(1'b0, 8'h10, 1'b0, 4'b0000, 32'h0,        8'h10, 1'b1);
    @(posedge clk); #1;
    chk("merge_a", 64'(o_a_data), 64'h11BB33DD);
    chk("merge_b", 64'(o_b_data), 64'h11BB33DD);

    // Same-cycle write on A and read on B: bypass returns the new word.
    cyc(1'b0, 8'h20, 1'b1, 4'b1111, 32'hDEADBEEF, 8'h20, 1'b1);
    @(posedge clk); #1;
    chk("bypass_b", 64'(o_b_data), 64'hDEADBEEF);

    // B holds its word while i_b_read is low.
    cyc(1'b0, 8'h20, 1'b0, 4'b0000, 32'h0, 8'h10, 1'b1);
    repeat (3) cyc(1'b0, 8'h30, 1'b1, 4'b1111, $urandom, 8'h20, 1'b0);
    @(posedge clk); #1;
    chk("hold_b_data", 64'(o_b_data), 64'h11BB33DD);
    chk("hold_b_valid", 64'(o_b_valid), 64'd0);

    // Requested clear with port A writes that must be dropped.
    cyc(1'b1, 8'h00, 1'b0, '0, '0, 8'h00, 1'b0);
    n = 0;
    do begin
      cyc(1'b0, 8'h10, 1'b1, 4'b1111, $urandom, 8'h10, 1'b1);
      @(posedge clk); #1;
      n++;
    end while (!o_ready && n < 1000);
    chk("clear_len_request", 64'(n), 64'(DEPTH));
    cyc(1'b0, 8'h10, 1'b0, '0, '0, 8'h10, 1'b1);
    @(posedge clk); #1;
    chk("after_clear_b", 64'(o_b_data), 64'd0);

    // Reset 100 cycles into a clear; clear pulses during the restart are ignored.
    cyc(1'b0, 8'h10, 1'b1, 4'b1111, 32'hCAFEF00D, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, '0, '0, 8'h00, 1'b0);
    repeat (100) cyc(1'b0, AW'($urandom), 1'b1, 4'b1111, $urandom, AW'($urandom), 1'b1);
    do_reset(1'b1);

    // Random traffic concentrated on a few addresses to provoke collisions.
    for (int i = 0; i < 4000; i++) begin
      logic [AW-1:0] aa, ba;
      aa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      ba = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, 15));
      cyc(($urandom_range(0, 799) == 0), aa, 1'($urandom), NB'($urandom), $urandom,
          ba, 1'($urandom));
    end
    repeat (DEPTH + 4) cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    chk("b_pending", 64'(bq.size()), 64'd0);

    // Latency-0, 64-bit, 16-word instance.
    @(negedge clk); d2_rst = 1'b1; #1;
    chk("d2_rst_ready", 64'(d2_ready), 64'd0);
    @(negedge clk); d2_rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!d2_ready && n < 100);
    chk("d2_clear_len", 64'(n), 64'd16);
    @(negedge clk); d2_a_addr = 4'd3; d2_b_addr = 4'd3; d2_b_read = 1'b1; #1;
    chk("d2_rd_zero", d2_b_rd, 64'd0);
    chk("d2_valid", 64'(d2_b_valid), 64'd1);
    @(negedge clk); d2_a_write = 1'b1; d2_a_be = 8'hFF; d2_a_data = 64'h1122334455667788; #1;
    chk("d2_a_prewrite", d2_a_rd, 64'd0);
    chk("d2_b_prewrite", d2_b_rd, 64'd0);
    @(negedge clk); d2_a_be = 8'b01010101; d2_a_data = 64'hAAAABBBBCCCCDDDD; #1;
    chk("d2_a_old", d2_a_rd, 64'h1122334455667788);
    @(negedge clk); d2_a_write = 1'b0; d2_b_read = 1'b0; #1;
    chk("d2_a_merged", d2_a_rd, 64'h11AA33BB55CC77DD);
    chk("d2_b_merged", d2_b_rd, 64'h11AA33BB55CC77DD);
    chk("d2_valid_low", 64'(d2_b_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
